ex_mem_stage_reg: RTL and testbench

Parametrised EX→MEM pipeline stage register with valid/ready handshake, a two-entry skid buffer, synchronous flush and synchronous reset. It sits between the execute stage and the data-memory stage. It replaces the free-running, unconditional stage register with one that can stall, absorb one back-pressured transfer without a combinational ready path, drop speculative instructions, and expose its contents to the forwarding unit.

---
 rtl/ex_mem_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline stage register: valid/ready handshake, two-entry skid buffer,
// synchronous flush, forwarding taps. Define EX_MEM_PERF_CNT_EN for stall/bubble counters.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic              in_memwrite,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic              out_memwrite,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [RD_W-1:0]   out_rd,
  output logic              fwd_en,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic              memwrite;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
  } stage_t;

  stage_t out_pl_reg, out_pl_next;
  stage_t skid_pl_reg, skid_pl_next;
  stage_t in_pl;
  logic   out_valid_reg, out_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  logic   acc, drn;

  always_comb begin
    in_pl          = '0;
    in_pl.memtoreg = in_memtoreg;
    in_pl.regwrite = in_regwrite;
    in_pl.memwrite = in_memwrite;
    in_pl.alu      = in_alu;
    in_pl.wdata    = in_wdata;
    in_pl.rd       = in_rd;
  end

  // Ready comes straight from a flop, so out_ready never reaches in_ready combinationally.
  assign in_ready = !skid_valid_reg;
  assign acc      = in_valid & in_ready & !flush;
  assign drn      = out_valid_reg & out_ready;

  always_comb begin
    out_pl_next     = out_pl_reg;
    skid_pl_next    = skid_pl_reg;
    out_valid_next  = out_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (skid_valid_reg && drn) begin
      // Skid entry is older than anything upstream, so it always goes first.
      out_pl_next     = skid_pl_reg;
      out_valid_next  = 1'b1;
      skid_valid_next = 1'b0;
    end else if (acc && (!out_valid_reg || drn)) begin
      out_pl_next    = in_pl;
      out_valid_next = 1'b1;
    end else if (acc) begin
      skid_pl_next    = in_pl;
      skid_valid_next = 1'b1;
    end else if (drn) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pl_reg     <= '0;
      skid_pl_reg    <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      out_pl_reg     <= out_pl_next;
      skid_pl_reg    <= skid_pl_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  logic [2:0] out_ctrl;
  logic [2:0] out_ctrl_masked;

  assign out_ctrl = {out_pl_reg.memtoreg, out_pl_reg.regwrite, out_pl_reg.memwrite};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ctrl_mask
      assign out_ctrl_masked[gi] = out_ctrl[gi] & out_valid_reg;
    end
  endgenerate

  assign out_valid    = out_valid_reg;
  assign out_memtoreg = out_ctrl_masked[2];
  assign out_regwrite = out_ctrl_masked[1];
  assign out_memwrite = out_ctrl_masked[0];
  assign out_alu      = out_pl_reg.alu;
  assign out_wdata    = out_pl_reg.wdata;
  assign out_rd       = out_pl_reg.rd;

  // Loads are not forwardable from here: their data only exists after the memory read.
  assign fwd_en   = out_valid_reg & out_pl_reg.regwrite & !out_pl_reg.memtoreg;
  assign fwd_rd   = out_pl_reg.rd;
  assign fwd_data = out_pl_reg.alu;

`ifdef EX_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] bubble_cnt_reg, bubble_cnt_next;

  always_comb begin
    stall_cnt_next  = stall_cnt_reg;
    bubble_cnt_next = bubble_cnt_reg;
    if (out_valid_reg && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    if (!out_valid_reg && (bubble_cnt_reg != {CNT_W{1'b1}}))
      bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
  end

  // Counters ignore flush on purpose; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      stall_cnt_reg  <= stall_cnt_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`else
  // No counters in this build; stage behaviour is unchanged.
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed self-checking bench for ex_mem_stage_reg with hand-computed expectations.
// Counter checks are compiled only when EX_MEM_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_ex_mem_stage_reg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic              in_memtoreg, in_regwrite, in_memwrite;
  logic [DATA_W-1:0] in_alu, in_wdata;
  logic [RD_W-1:0]   in_rd;
  logic              flush;
  logic              out_valid, out_ready;
  logic              out_memtoreg, out_regwrite, out_memwrite;
  logic [DATA_W-1:0] out_alu, out_wdata;
  logic [RD_W-1:0]   out_rd;
  logic              fwd_en;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_data;
`ifdef EX_MEM_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_memwrite(in_memwrite),
    .in_alu(in_alu), .in_wdata(in_wdata), .in_rd(in_rd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_memtoreg(out_memtoreg), .out_regwrite(out_regwrite), .out_memwrite(out_memwrite),
    .out_alu(out_alu), .out_wdata(out_wdata), .out_rd(out_rd),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`ifdef EX_MEM_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic mtr, input logic rw, input logic mw,
                       input logic [31:0] alu, input logic [4:0] rd);
    in_valid    = v;
    in_memtoreg = mtr;
    in_regwrite = rw;
    in_memwrite = mw;
    in_alu      = alu;
    in_wdata    = alu ^ 32'hFFFF_0000;
    in_rd       = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_alu", out_alu, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_fwd_en", fwd_en, 0);

    // Streaming, 1-cycle latency, in_ready constant
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h10 + i, 5'(i));
      check($sformatf("stream_in_ready_%0d", i), in_ready, 1);
      tick();
      check($sformatf("stream_valid_%0d", i), out_valid, 1);
      check($sformatf("stream_alu_%0d", i), out_alu, 32'h10 + i);
    end
    idle();
    tick();
    check("stream_drained", out_valid, 0);

    // Back-pressure into the skid entry
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hA, 5'd1);
    tick();
    check("bp_first_alu", out_alu, 32'hA);
    check("bp_first_ready", in_ready, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hB, 5'd2);
    tick();
    check("bp_held_alu", out_alu, 32'hA);
    check("bp_full_ready", in_ready, 0);
    idle();
    out_ready = 1'b1;
    check("bp_emit_a", out_alu, 32'hA);
    tick();
    check("bp_emit_b", out_alu, 32'hB);
    check("bp_emit_b_valid", out_valid, 1);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_drained", out_valid, 0);

    // Flush with both entries full, input dropped
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1, 5'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h2, 5'd2);
    tick();
    check("fl_full_ready", in_ready, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hC, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_regwrite_masked", out_regwrite, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_no_c_%0d", i), out_valid, 0);
    end

    // Flush from empty with in_ready=1 also drops the input
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hD, 5'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_empty_dropped", out_valid, 0);

    // Masking and forwarding
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 5'd7);
    tick();
    idle();
    check("st_memwrite", out_memwrite, 1);
    check("st_fwd_en", fwd_en, 0);
    check("st_rd", out_rd, 7);
    tick();
    check("st_stall_memwrite", out_memwrite, 1);
    out_ready = 1'b1;
    tick();
    check("st_drained_memwrite_masked", out_memwrite, 0);
    check("st_drained_rd_held", out_rd, 7);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 5'd4);
    tick();
    check("ld_memtoreg", out_memtoreg, 1);
    check("ld_fwd_en", fwd_en, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h55, 5'd3);
    tick();
    idle();
    check("alu_fwd_en", fwd_en, 1);
    check("alu_fwd_rd", fwd_rd, 3);
    check("alu_fwd_data", fwd_data, 32'h55);
    check("alu_wdata", out_wdata, 32'h55 ^ 32'hFFFF_0000);
    tick();
    check("alu_drained_fwd_en", fwd_en, 0);
    check("alu_drained_regwrite", out_regwrite, 0);

    // Reset while both entries are full
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h66, 5'd6);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h77, 5'd7);
    tick();
    idle();
    check("rs_full_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_out_valid", out_valid, 0);
    check("rs_in_ready", in_ready, 1);
    check("rs_regwrite", out_regwrite, 0);
    check("rs_out_alu", out_alu, 0);
    check("rs_out_rd", out_rd, 0);
    out_ready = 1'b1;
    tick();
    check("rs_skid_gone", out_valid, 0);

`ifdef EX_MEM_PERF_CNT_EN
    // Stall counter: 5 cycles valid without ready
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("pc_rst_stall", stall_cnt, 0);
    check("pc_rst_bubble", bubble_cnt, 0);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h99, 5'd9);
    tick();
    idle();
    check("pc_stall_start", stall_cnt, 0);
    for (int i = 0; i < 5; i++) tick();
    check("pc_stall_5", stall_cnt, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("pc_stall_after_flush", stall_cnt, 6);
    // Bubble counter saturates
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("pc_bubble_sat", bubble_cnt, 15);
    check("pc_stall_cleared", stall_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
